// File: rtl/phase_seq_mult_ctrl.sv
// Command-driven operand sequencer for a fixed-latency pipelined multiplier, with credit-gated issue into a FWFT FIFO / AXI-Stream output.
// Optional build macro: PHASE_SEQ_ROUND_EN (round-half-up phase scaling instead of truncation).
module phase_seq_mult_ctrl #(
    parameter int unsigned LAT        = 6,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned OUT_SHIFT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [63:0] s_tdata,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    input  logic [63:0] mult_p,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] m_tdata,
    output logic        m_tlast,
    output logic        busy
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(LAT + FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_next;

    logic [31:0]           freq;
    logic [31:0]           count_m1;
    logic [31:0]           n;
    logic [LAT-1:0]        pipe_v;
    logic [LAT-1:0]        pipe_l;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_cnt;
    logic [31:0]           mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  cmd_acc;
    logic                  issue;
    logic                  credit;
    logic                  push;
    logic                  pop;
    logic [31:0]           phase;

    assign s_tready = (state == IDLE) && !rst;
    assign cmd_acc  = s_tvalid && s_tready;
    // Outstanding words (in flight plus buffered) never exceed the FIFO depth.
    assign credit   = (inflight + fifo_cnt) < CW'(FIFO_DEPTH);
    assign push     = pipe_v[LAT-1];
    assign pop      = m_tvalid && m_tready;
    assign m_tvalid = (fifo_cnt != '0);
    assign m_tdata  = mem_data[rd_ptr];
    assign m_tlast  = mem_last[rd_ptr];
    assign busy     = (state != IDLE) || (fifo_cnt != '0);

    // Scale the returned product down to a 32-bit phase word.
    always_comb begin
        phase = 32'(mult_p >> OUT_SHIFT);
`ifdef PHASE_SEQ_ROUND_EN
        phase = phase + 32'(mult_p[OUT_SHIFT-1]);
`endif
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_acc && (s_tdata[63:32] != 32'd0)) state_next = ISSUE;
            end
            ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    if (n == count_m1) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand issue, token pipe matched to multiplier latency, and output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq     <= '0;
            count_m1 <= '0;
            n        <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
            pipe_v   <= '0;
            pipe_l   <= '0;
            inflight <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_last <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_data[i] <= '0;
        end else begin
            if (cmd_acc) begin
                freq     <= s_tdata[31:0];
                count_m1 <= s_tdata[63:32] - 32'd1;
                n        <= '0;
            end
            if (issue) begin
                mult_a <= freq;
                mult_b <= n;
                n      <= n + 32'd1;
            end
            pipe_v[0] <= issue;
            pipe_l[0] <= issue && (n == count_m1);
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
            inflight <= inflight + CW'(issue) - CW'(push);
            if (push) begin
                mem_data[wr_ptr] <= phase;
                mem_last[wr_ptr] <= pipe_l[LAT-1];
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

endmodule
